// File: rtl/aes_cbc_dec_ctrl.sv
// Sequencing controller for a single AES-128 decipher core: accepts one ciphertext
// block at a time, starts the core, then applies CBC chaining (or ECB pass-through).
module aes_cbc_dec_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [127:0]         s_iv,
  input  logic                 s_iv_load,
  input  logic [127:0]         s_block,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [127:0]         m_block,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [127:0]         core_block,
  output logic                 core_valid,
  input  logic                 core_ready,
  input  logic [127:0]         core_result,
  output logic [CNT_WIDTH-1:0] block_count,
  output logic                 busy,
  output logic [2:0]           state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid never waits on ready, and data is held stable while valid && !ready.

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    OUTPUT    = 3'd4
  } state_t;

  state_t         state, state_nxt;
  logic           accept, done, deliver;
  logic [127:0]   chain, cipher_hold;
  logic           mode_hold;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done      = 1'b0;
    deliver   = 1'b0;
    case (state)
      IDLE: begin
        // An IV load in the same cycle takes priority; the block waits.
        if (!s_iv_load && s_valid) begin
          accept    = 1'b1;
          state_nxt = START;
        end
      end
      START:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (!core_ready) state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (core_ready) begin
          done      = 1'b1;
          state_nxt = OUTPUT;
        end
      end
      OUTPUT: begin
        if (m_ready) begin
          deliver   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign s_ready    = (state == IDLE) && !s_iv_load;
  assign core_valid = (state == START);
  assign busy       = (state != IDLE);
  assign state_dbg  = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain       <= '0;
      cipher_hold <= '0;
      mode_hold   <= 1'b0;
      core_block  <= '0;
      m_block     <= '0;
      m_valid     <= 1'b0;
      block_count <= '0;
    end else begin
      if (state == IDLE && s_iv_load) chain <= s_iv;
      if (accept) begin
        core_block  <= s_block;
        cipher_hold <= s_block;
        mode_hold   <= mode;
      end
      if (done) begin
        m_block <= core_result ^ (mode_hold ? chain : 128'd0);
        m_valid <= 1'b1;
        // The ciphertext just decrypted becomes the chaining value for the next block.
        if (mode_hold) chain <= cipher_hold;
      end
      if (deliver) begin
        m_valid     <= 1'b0;
        block_count <= block_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_aes_cbc_dec_ctrl.sv
// Bench for aes_cbc_dec_ctrl: a behavioural AES core stand-in, a chaining reference
// model with an expected queue, directed FIPS-197/SP800-38A vectors and random traffic.
module tb_aes_cbc_dec_ctrl;

  localparam int CW = 4;  // narrow counter so wrap-around is reached

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           mode = 1'b0;
  logic [127:0]   s_iv = '0;
  logic           s_iv_load = 1'b0;
  logic [127:0]   s_block = '0;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic [127:0]   m_block;
  logic           m_valid;
  logic           m_ready = 1'b1;
  logic [127:0]   core_block;
  logic           core_valid;
  logic           core_ready;
  logic [127:0]   core_result;
  logic [CW-1:0]  block_count;
  logic           busy;
  logic [2:0]     state_dbg;

  aes_cbc_dec_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .s_iv(s_iv), .s_iv_load(s_iv_load),
    .s_block(s_block), .s_valid(s_valid), .s_ready(s_ready),
    .m_block(m_block), .m_valid(m_valid), .m_ready(m_ready),
    .core_block(core_block), .core_valid(core_valid), .core_ready(core_ready),
    .core_result(core_result), .block_count(block_count), .busy(busy),
    .state_dbg(state_dbg)
  );

  // ---------------- known vectors ----------------
  logic [127:0] IV   = 128'h000102030405060708090a0b0c0d0e0f;
  logic [127:0] ECB_C = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  logic [127:0] ECB_P = 128'h6bc1bee22e409f96e93d7e117393172a;
  logic [127:0] cbc_c [4];
  logic [127:0] cbc_p [4];
  logic [127:0] tab_c [5];
  logic [127:0] tab_d [5];

  // Raw AES decipher outputs for the vector ciphertexts; anything else gets a
  // fixed scrambling so random traffic still has a distinct, predictable result.
  function automatic logic [127:0] core_f(input logic [127:0] c);
    for (int i = 0; i < 5; i++) if (tab_c[i] == c) return tab_d[i];
    return {c[62:0], c[127:63]} ^ 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
  endfunction

  // ---------------- core stand-in ----------------
  int           core_lat = 2;
  int           core_cnt;
  logic [127:0] core_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_ready <= 1'b1;
      core_cnt   <= 0;
      core_q     <= '0;
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) core_ready <= 1'b1;
    end else if (core_valid) begin
      core_q     <= core_block;
      core_ready <= 1'b0;
      core_cnt   <= core_lat;
    end
  end
  assign core_result = core_ready ? core_f(core_q) : 128'd0;

  // ---------------- scoreboard / reference model ----------------
  int             n_checks = 0;
  int             n_fail = 0;
  logic [127:0]   exp_q[$];
  logic [127:0]   out_log[$];
  logic [127:0]   model_chain = '0;
  logic [CW-1:0]  exp_cnt = '0;
  logic [127:0]   last_acc = '0;
  int             n_core_valid = 0;
  int             cyc = 0;
  int             rdy_mode = 0;  // 0: always ready, 1: random, 2: held low

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ($urandom_range(0, 3) != 0);
      default: m_ready = 1'b0;
    endcase
  end

  // Output monitor: sampled on the falling edge, away from the active edge.
  logic         pv, pr, pcv, pcr;
  logic [127:0] pb;
  int           rise_cyc = 0;
  always @(negedge clk) begin
    if (rst) begin
      pv = 0; pr = 0; pcv = 0; pcr = 1; pb = '0;
    end else begin
      if (core_valid) begin
        n_core_valid++;
        check("core_valid_one_cycle", 128'(pcv), 128'(0));
        check("core_block", core_block, last_acc);
        check("core_valid_while_out", 128'(m_valid), 128'(0));
      end
      if (core_ready && !pcr) rise_cyc = cyc;
      if (m_valid && !pv) check("m_valid_latency", 128'(cyc - rise_cyc), 128'(1));
      if (pv && !pr) begin
        check("m_valid_hold", 128'(m_valid), 128'(1));
        check("m_block_hold", m_block, pb);
      end
      if (pv && pr) check("m_valid_drop", 128'(m_valid), 128'(0));
      if (m_valid) check("s_ready_during_out", 128'(s_ready), 128'(0));
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", 128'(1), 128'(0));
        else check("m_block", m_block, exp_q.pop_front());
        check("block_count_pre", 128'(block_count), 128'(exp_cnt));
        exp_cnt++;
        out_log.push_back(m_block);
      end
      pv = m_valid; pr = m_ready; pb = m_block; pcv = core_valid; pcr = core_ready;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at posedge+1 right after the accepting edge.
  task automatic finish_accept(input logic [127:0] c, input logic m);
    s_valid = 1'b0;
    s_block = rand128();
    mode    = ~m;
    last_acc = c;
    exp_q.push_back(core_f(c) ^ (m ? model_chain : 128'd0));
    if (m) model_chain = c;
    check("core_valid_after_accept", 128'(core_valid), 128'(1));
  endtask

  task automatic send_block(input logic [127:0] c, input logic m);
    bit got = 0;
    @(posedge clk); #1;
    s_block = c; mode = m; s_valid = 1'b1;
    for (int t = 0; t < 400 && !got; t++) begin
      @(negedge clk);
      if (s_ready) got = 1;
    end
    if (!got) begin
      check("s_ready_timeout", 128'(0), 128'(1));
      s_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    finish_accept(c, m);
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int t = 0; t < 2000 && !ok; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) ok = 1;
    end
    if (!ok) check("drain_timeout", 128'(0), 128'(1));
  endtask

  task automatic load_iv(input logic [127:0] iv);
    @(posedge clk); #1;
    s_iv = iv; s_iv_load = 1'b1;
    @(negedge clk);
    check("s_ready_iv_load", 128'(s_ready), 128'(0));
    @(posedge clk); #1;
    s_iv_load = 1'b0;
    s_iv = rand128();
    model_chain = iv;
  endtask

  task automatic run_cbc(input string tag);
    int base;
    load_iv(IV);
    base = out_log.size();
    for (int i = 0; i < 4; i++) send_block(cbc_c[i], 1'b1);
    wait_drain();
    for (int i = 0; i < 4; i++)
      if (out_log.size() > base + i) check(tag, out_log[base + i], cbc_p[i]);
      else check({tag, "_missing"}, 128'(0), 128'(1));
  endtask

  // ---------------- main sequence ----------------
  logic [CW-1:0] c0;
  int            n0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    cbc_c[0] = 128'h7649abac8119b246cee98e9b12e9197d; cbc_p[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
    cbc_c[1] = 128'h5086cb9b507219ee95db113a917678b2; cbc_p[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    cbc_c[2] = 128'h73bed6b8e3c1743b7116e69e22229516; cbc_p[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    cbc_c[3] = 128'h3ff1caa1681fac09120eca307586e1a7; cbc_p[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;
    tab_c[0] = ECB_C; tab_d[0] = ECB_P;
    tab_c[1] = cbc_c[0]; tab_d[1] = cbc_p[0] ^ IV;
    for (int i = 1; i < 4; i++) begin
      tab_c[i+1] = cbc_c[i];
      tab_d[i+1] = cbc_p[i] ^ cbc_c[i-1];
    end

    // reset values while reset is held
    repeat (3) @(posedge clk); #1;
    check("rst_m_valid", 128'(m_valid), 128'(0));
    check("rst_core_valid", 128'(core_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_s_ready", 128'(s_ready), 128'(1));
    check("rst_m_block", m_block, 128'(0));
    check("rst_core_block", core_block, 128'(0));
    check("rst_block_count", 128'(block_count), 128'(0));
    @(negedge clk); rst = 1'b0;

    // ECB vector, fast core
    core_lat = 2;
    send_block(ECB_C, 1'b0);
    wait_drain();
    check("ecb_out", out_log[$], ECB_P);
    check("ecb_count", 128'(block_count), 128'(1));
    check("ecb_core_valid_pulses", 128'(n_core_valid), 128'(1));

    // CBC chain, slow core, with an IV load attempted mid-flight (must be ignored)
    core_lat = 12;
    load_iv(IV);
    send_block(cbc_c[0], 1'b1);
    send_block(cbc_c[1], 1'b1);
    s_iv = rand128(); s_iv_load = 1'b1;
    @(posedge clk); #1; s_iv_load = 1'b0;
    send_block(cbc_c[2], 1'b1);
    send_block(cbc_c[3], 1'b1);
    wait_drain();
    for (int i = 0; i < 4; i++) check("cbc_slow", out_log[1 + i], cbc_p[i]);
    check("cbc_count", 128'(block_count), 128'(5));

    // same CBC chain on a fast core
    core_lat = 1;
    run_cbc("cbc_fast");
    check("cbc_fast_count", 128'(block_count), 128'(9));

    // back-pressure
    core_lat = 3;
    rdy_mode = 2;
    @(posedge clk); #1;
    send_block(ECB_C, 1'b0);
    for (int t = 0; t < 100 && !m_valid; t++) @(negedge clk);
    check("bp_m_valid", 128'(m_valid), 128'(1));
    n0 = n_core_valid;
    c0 = block_count;
    repeat (20) @(negedge clk);
    check("bp_m_block", m_block, ECB_P);
    check("bp_no_core_valid", 128'(n_core_valid), 128'(n0));
    check("bp_count_held", 128'(block_count), 128'(c0));
    rdy_mode = 0;
    wait_drain();
    c0 = c0 + 1'b1;
    check("bp_count_once", 128'(block_count), 128'(c0));

    // IV load and block valid in the same IDLE cycle
    @(posedge clk); #1;
    s_iv = IV; s_iv_load = 1'b1; s_block = cbc_c[0]; s_valid = 1'b1; mode = 1'b1;
    @(negedge clk);
    check("collide_s_ready", 128'(s_ready), 128'(0));
    @(posedge clk); #1;
    check("collide_not_accepted", 128'(busy), 128'(0));
    s_iv_load = 1'b0;
    model_chain = IV;
    @(negedge clk);
    check("collide_ready_next", 128'(s_ready), 128'(1));
    @(posedge clk); #1;
    finish_accept(cbc_c[0], 1'b1);
    wait_drain();
    check("collide_out", out_log[$], cbc_p[0]);

    // reset while waiting on the core
    core_lat = 12;
    send_block(cbc_c[1], 1'b1);
    repeat (5) @(posedge clk); #1;
    check("pre_rst_busy", 128'(busy), 128'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_m_valid", 128'(m_valid), 128'(0));
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_core_valid", 128'(core_valid), 128'(0));
    check("mid_rst_block_count", 128'(block_count), 128'(0));
    exp_q.delete();
    model_chain = '0;
    exp_cnt = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_block(cbc_c[0], 1'b1);   // chain cleared by reset: raw core output expected
    wait_drain();
    check("post_rst_chain_zero", out_log[$], tab_d[1]);
    run_cbc("post_rst_cbc");

    // random traffic with random back-pressure and core latency
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        wait_drain();
        load_iv(rand128());
      end
      core_lat = $urandom_range(1, 14);
      if ($urandom_range(0, 5) == 0) send_block(cbc_c[$urandom_range(0, 3)], 1'($urandom_range(0, 1)));
      else send_block(rand128(), 1'($urandom_range(0, 1)));
    end
    wait_drain();
    rdy_mode = 0;
    check("final_count", 128'(block_count), 128'(exp_cnt));
    check("final_queue_empty", 128'(exp_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
